// File: rtl/cim_ctrl_if.sv
// cim_ctrl_if -- command, input-stream and result-stream signals of cim_ctrl.
//
// Handshake rule for all three channels (cmd_*, in_*, res_*):
//   a transfer happens on a rising clk edge where valid and ready are both 1.
//   The producer keeps valid and its payload stable until that transfer.
//   ready may depend on state only, never on the valid of the same channel.
//
// master: command/stream producer and result consumer (host side).
// slave : the controller.
interface cim_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;     // 0 = LOAD weights, 1 = COMPUTE
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;    // number of words

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_idx;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, in_valid, in_data, res_ready,
    input  cmd_ready, in_ready, res_valid, res_data, res_idx
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, in_valid, in_data, res_ready,
    output cmd_ready, in_ready, res_valid, res_data, res_idx
  );
endinterface

// File: rtl/cim_ctrl.sv
// cim_ctrl -- sequencer for a compute-in-memory macro.
//
// A LOAD command writes cmd_len words from the input stream into the macro at
// base, base+4, ...  A COMPUTE command clears the macro output registers,
// accumulates cmd_len input words at base, base+8, ... and then reads the
// eight output registers out over the result stream.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   bus               cim_ctrl_if.slave: command / input / result channels
//   busy              high whenever the controller is not idle
//   cs, web, cimeb, partial_sum_eb, reset_output_reg, output_reg, address,
//   input_data        macro control outputs (combinational decodes)
//   cim_output        macro read data
//   state_dbg         current FSM state, for observation only
module cim_ctrl (
  input  logic        clk,
  input  logic        rst,
  cim_ctrl_if.slave   bus,
  output logic        busy,
  output logic        cs,
  output logic        web,
  output logic        cimeb,
  output logic        partial_sum_eb,
  output logic        reset_output_reg,
  output logic [3:0]  output_reg,
  output logic [31:0] address,
  output logic [31:0] input_data,
  input  logic [31:0] cim_output,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CLR  = 3'd2,
    S_ACC  = 3'd3,
    S_READ = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] base_r;
  logic [7:0]  len_r;
  logic [7:0]  k;
  logic [2:0]  j;

  logic        len_nz;
  logic        last_word;

  assign len_nz    = (len_r != 8'd0);
  assign last_word = (k == len_r - 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      base_r <= '0;
      len_r  <= '0;
      k      <= '0;
      j      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            base_r <= bus.cmd_addr;
            len_r  <= bus.cmd_len;
            k      <= '0;
            j      <= '0;
            state  <= bus.cmd_op ? S_CLR : S_LOAD;
          end
        end
        S_LOAD: begin
          // An empty LOAD spends exactly one cycle here and touches nothing.
          if (!len_nz) begin
            state <= S_IDLE;
          end else if (bus.in_valid) begin
            // k stops at len-1 so it never points past the command's window.
            if (last_word) state <= S_IDLE;
            else           k     <= k + 8'd1;
          end
        end
        S_CLR: begin
          state <= len_nz ? S_ACC : S_READ;
        end
        S_ACC: begin
          if (bus.in_valid) begin
            if (last_word) state <= S_READ;
            else           k     <= k + 8'd1;
          end
        end
        S_READ: begin
          if (bus.res_ready) begin
            if (j == 3'd7) state <= S_IDLE;
            else           j     <= j + 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    // cmd_ready is gated by rst so it stays low for the whole reset pulse.
    bus.cmd_ready    = (state == S_IDLE) && !rst;
    bus.in_ready     = 1'b0;
    bus.res_valid    = 1'b0;
    bus.res_data     = '0;
    bus.res_idx      = '0;
    cs               = 1'b0;
    web              = 1'b0;
    cimeb            = 1'b0;
    partial_sum_eb   = 1'b0;
    reset_output_reg = 1'b0;
    output_reg       = '0;
    address          = '0;
    input_data       = '0;
    case (state)
      S_LOAD: begin
        // With len==0 nothing may be written, so no word is accepted either.
        bus.in_ready = len_nz;
        cs           = bus.in_valid && len_nz;
        web          = bus.in_valid && len_nz;
        address      = base_r + {22'b0, k, 2'b00};
        input_data   = bus.in_data;
      end
      S_CLR: begin
        cs               = 1'b1;
        cimeb            = 1'b1;
        reset_output_reg = 1'b1;
      end
      S_ACC: begin
        bus.in_ready   = 1'b1;
        cs             = bus.in_valid;
        cimeb          = 1'b1;
        partial_sum_eb = 1'b1;
        address        = base_r + {21'b0, k, 3'b000};
        input_data     = bus.in_data;
      end
      S_READ: begin
        // j only moves on a result transfer, so a stalled result is held.
        cimeb         = 1'b1;
        output_reg    = {1'b0, j};
        bus.res_valid = 1'b1;
        bus.res_idx   = j;
        bus.res_data  = cim_output;
      end
      default: ;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule
